exe_stage: RTL

//  Execute stage between the ID/EXE register and MEM. Computes the ALU result from
//  the register/immediate operands latched by ID/EXE, then registers result,
//  rd address and write-back enable for MEM. MUL/DIVU/REMU run on an iterative

---
 rtl/exe_stage.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : exe_stage                                                 |
// | Brief    : Execute stage. Single-cycle ALU plus an optional          |
// |            iterative MUL/DIVU/REMU unit. Result, rd and write-back   |
// |            enable are registered towards MEM.                        |
// |            Build macro MULDIV_EN: when defined the iterative unit    |
// |            and its IDLE/BUSY/DONE FSM are built; when undefined ops  |
// |            11-13 produce 0 in a single cycle.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module exe_stage #(
    parameter int XLEN    = 32,
    parameter int MD_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex,
    input  logic            wb_en_ex,
    input  logic [4:0]      rd_addr_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic            use_imm_ex,
    input  logic [3:0]      alu_op_ex,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            stall_ex,
    output logic            valid_mem,
    output logic            wb_en_mem,
    output logic [4:0]      rd_addr_mem,
    output logic [XLEN-1:0] alu_out_mem
);

    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_sll   = 4'd2;
    localparam logic [3:0] c_op_slt   = 4'd3;
    localparam logic [3:0] c_op_sltu  = 4'd4;
    localparam logic [3:0] c_op_xor   = 4'd5;
    localparam logic [3:0] c_op_srl   = 4'd6;
    localparam logic [3:0] c_op_sra   = 4'd7;
    localparam logic [3:0] c_op_or    = 4'd8;
    localparam logic [3:0] c_op_and   = 4'd9;
    localparam logic [3:0] c_op_passb = 4'd10;
    localparam logic [3:0] c_op_mul   = 4'd11;
    localparam logic [3:0] c_op_divu  = 4'd12;
    localparam logic [3:0] c_op_remu  = 4'd13;

    // Only 1 or 2 result bits per iteration are supported by the step logic
    if ((MD_STEP != 1) && (MD_STEP != 2)) begin : g_md_step_check
        $error("exe_stage: MD_STEP must be 1 or 2");
    end

    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_res;
    logic            w_wb_req;

    // Interface between the (optional) iterative unit and the output register
    logic            w_md_hold;
    logic            w_md_done;
    logic            w_md_wb;
    logic [4:0]      w_md_rd;
    logic [XLEN-1:0] w_md_res;

    logic            r_valid_q, w_valid_d;
    logic            r_wb_en_q, w_wb_en_d;
    logic [4:0]      r_rd_q,    w_rd_d;
    logic [XLEN-1:0] r_alu_q,   w_alu_d;

    assign w_op_b   = use_imm_ex ? imm_ex : rs2_data_ex;
    assign w_wb_req = wb_en_ex & valid_ex & (rd_addr_ex != 5'd0);

    // Single-cycle ALU; shift amounts come from B[4:0]
    always_comb begin
        w_alu_res = '0;
        case (alu_op_ex)
            c_op_add:   w_alu_res = rs1_data_ex + w_op_b;
            c_op_sub:   w_alu_res = rs1_data_ex - w_op_b;
            c_op_sll:   w_alu_res = rs1_data_ex << w_op_b[4:0];
            c_op_slt:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data_ex) < $signed(w_op_b))};
            c_op_sltu:  w_alu_res = {{(XLEN-1){1'b0}}, (rs1_data_ex < w_op_b)};
            c_op_xor:   w_alu_res = rs1_data_ex ^ w_op_b;
            c_op_srl:   w_alu_res = rs1_data_ex >> w_op_b[4:0];
            c_op_sra:   w_alu_res = $unsigned($signed(rs1_data_ex) >>> w_op_b[4:0]);
            c_op_or:    w_alu_res = rs1_data_ex | w_op_b;
            c_op_and:   w_alu_res = rs1_data_ex & w_op_b;
            c_op_passb: w_alu_res = w_op_b;
`ifdef MULDIV_EN
            // Division by zero bypasses the iterative unit
            c_op_divu:  w_alu_res = '1;
            c_op_remu:  w_alu_res = rs1_data_ex;
`endif
            default:    w_alu_res = '0;
        endcase
    end

`ifdef MULDIV_EN
    localparam int                 c_iters    = XLEN / MD_STEP;
    localparam int                 c_cnt_w    = $clog2(c_iters + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_iters);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);
    localparam logic [1:0]         c_kind_mul  = 2'd0;
    localparam logic [1:0]         c_kind_divu = 2'd1;
    localparam logic [1:0]         c_kind_remu = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t          r_state_q, w_state_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;
    // MUL: a = multiplicand, b = multiplier, acc = product
    // DIV: a = dividend shifting out / quotient shifting in, b = divisor, acc = remainder
    logic [XLEN-1:0]    r_a_q,     w_a_d;
    logic [XLEN-1:0]    r_b_q,     w_b_d;
    logic [XLEN-1:0]    r_acc_q,   w_acc_d;
    logic [1:0]         r_kind_q,  w_kind_d;
    logic [4:0]         r_md_rd_q, w_md_rd_d;
    logic               r_md_wb_q, w_md_wb_d;

    logic               w_is_md;
    logic               w_div0;
    logic               w_md_start;
    logic [1:0]         w_kind_new;
    logic [XLEN-1:0]    w_a_step;
    logic [XLEN-1:0]    w_b_step;
    logic [XLEN-1:0]    w_acc_step;
    logic [XLEN:0]      w_rem_ext;

    assign w_is_md    = (alu_op_ex == c_op_mul) || (alu_op_ex == c_op_divu) ||
                        (alu_op_ex == c_op_remu);
    assign w_div0     = ((alu_op_ex == c_op_divu) || (alu_op_ex == c_op_remu)) &&
                        (w_op_b == '0);
    assign w_md_start = (r_state_q == S_IDLE) && valid_ex && w_is_md && !w_div0 && !flush;
    assign w_kind_new = (alu_op_ex == c_op_mul)  ? c_kind_mul  :
                        (alu_op_ex == c_op_divu) ? c_kind_divu : c_kind_remu;

    // MD_STEP iterations of shift-add multiply or restoring divide
    always_comb begin
        w_a_step   = r_a_q;
        w_b_step   = r_b_q;
        w_acc_step = r_acc_q;
        w_rem_ext  = '0;
        for (int i = 0; i < MD_STEP; i++) begin
            if (r_kind_q == c_kind_mul) begin
                if (w_b_step[0]) begin
                    w_acc_step = w_acc_step + w_a_step;
                end
                w_a_step = w_a_step << 1;
                w_b_step = w_b_step >> 1;
            end else begin
                w_rem_ext = {w_acc_step, w_a_step[XLEN-1]};
                w_a_step  = w_a_step << 1;
                if (w_rem_ext >= {1'b0, w_b_step}) begin
                    w_rem_ext   = w_rem_ext - {1'b0, w_b_step};
                    w_a_step[0] = 1'b1;
                end
                w_acc_step = w_rem_ext[XLEN-1:0];
            end
        end
    end

    // FSM next state: accept, iterate, then wait for MEM to take the result
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_acc_d   = r_acc_q;
        w_kind_d  = r_kind_q;
        w_md_rd_d = r_md_rd_q;
        w_md_wb_d = r_md_wb_q;
        if (flush) begin
            w_state_d = S_IDLE;
            w_cnt_d   = '0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_md_start) begin
                        w_state_d = S_BUSY;
                        w_cnt_d   = c_cnt_load;
                        w_a_d     = rs1_data_ex;
                        w_b_d     = w_op_b;
                        w_acc_d   = '0;
                        w_kind_d  = w_kind_new;
                        w_md_rd_d = rd_addr_ex;
                        w_md_wb_d = wb_en_ex && (rd_addr_ex != 5'd0);
                    end
                end
                S_BUSY: begin
                    w_a_d   = w_a_step;
                    w_b_d   = w_b_step;
                    w_acc_d = w_acc_step;
                    w_cnt_d = r_cnt_q - c_cnt_last;
                    if (r_cnt_q == c_cnt_last) begin
                        w_state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!mem_stall) begin
                        w_state_d = S_IDLE;
                    end
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    // Iterative unit state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_acc_q   <= '0;
            r_kind_q  <= '0;
            r_md_rd_q <= '0;
            r_md_wb_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_acc_q   <= w_acc_d;
            r_kind_q  <= w_kind_d;
            r_md_rd_q <= w_md_rd_d;
            r_md_wb_q <= w_md_wb_d;
        end
    end

    assign w_md_hold = w_md_start || (r_state_q == S_BUSY);
    assign w_md_done = (r_state_q == S_DONE);
    assign w_md_wb   = r_md_wb_q;
    assign w_md_rd   = r_md_rd_q;
    assign w_md_res  = (r_kind_q == c_kind_divu) ? r_a_q : r_acc_q;
    // A flush releases the pipeline even in the middle of an iteration
    assign stall_ex  = mem_stall || w_md_start || (!flush && (r_state_q == S_BUSY));
`else
    assign w_md_hold = 1'b0;
    assign w_md_done = 1'b0;
    assign w_md_wb   = 1'b0;
    assign w_md_rd   = '0;
    assign w_md_res  = '0;
    assign stall_ex  = mem_stall;
`endif

    // EXE/MEM register next value: hold on mem_stall, bubble when nothing completes
    always_comb begin
        w_valid_d = r_valid_q;
        w_wb_en_d = r_wb_en_q;
        w_rd_d    = r_rd_q;
        w_alu_d   = r_alu_q;
        if (!mem_stall) begin
            if (flush || w_md_hold) begin
                w_valid_d = 1'b0;
                w_wb_en_d = 1'b0;
            end else if (w_md_done) begin
                w_valid_d = 1'b1;
                w_wb_en_d = w_md_wb;
                w_rd_d    = w_md_rd;
                w_alu_d   = w_md_res;
            end else begin
                w_valid_d = valid_ex;
                w_wb_en_d = w_wb_req;
                w_rd_d    = rd_addr_ex;
                w_alu_d   = w_alu_res;
            end
        end
    end

    // EXE/MEM output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_wb_en_q <= 1'b0;
            r_rd_q    <= '0;
            r_alu_q   <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_wb_en_q <= w_wb_en_d;
            r_rd_q    <= w_rd_d;
            r_alu_q   <= w_alu_d;
        end
    end

    assign valid_mem   = r_valid_q;
    assign wb_en_mem   = r_wb_en_q;
    assign rd_addr_mem = r_rd_q;
    assign alu_out_mem = r_alu_q;

endmodule
`default_nettype wire
